// File: rtl/ti_adc_frame_align.sv
// ti_adc_frame_align
//   Aligns interleaved sub-ADC frames: per-way offset correction with clamp,
//   way masking, frame index stamping, and a first-word-fall-through frame
//   FIFO towards the downstream consumer.
//
// Optional feature: define TI_ADC_OFFSET_CAL_EN to enable per-way offset
//   subtraction and clamping. Without it, cal_offset is ignored and codes pass
//   through unchanged (masking, latency and FIFO behaviour are identical).
//
// Ports
//   clk         core clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    a complete frame is present on in_data
//   in_data     ADC_WAYS codes, way i at [i*ADC_BITS +: ADC_BITS], way 0 first
//   cal_offset  per-way signed offset, same packing with CAL_BITS per way
//   way_mask    1 = way enabled, 0 = replaced by mid-code
//   clr_ovf     clears the sticky overflow flag (set wins)
//   out_ready   downstream accepts the head frame
//   out_valid   head frame available
//   out_data    corrected head frame
//   out_frame   frame index of the head frame
//   fifo_level  number of frames held
//   overflow    sticky, set when a frame is dropped on a full FIFO
module ti_adc_frame_align #(
  parameter int ADC_WAYS   = 8,
  parameter int ADC_BITS   = 9,
  parameter int CAL_BITS   = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [ADC_WAYS*ADC_BITS-1:0]       in_data,
  input  logic [ADC_WAYS*CAL_BITS-1:0]       cal_offset,
  input  logic [ADC_WAYS-1:0]                way_mask,
  input  logic                               clr_ovf,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [ADC_WAYS*ADC_BITS-1:0]       out_data,
  output logic [CNT_BITS-1:0]                out_frame,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DW    = ADC_WAYS * ADC_BITS;
  localparam int EW    = ADC_BITS + 2;

  localparam logic [ADC_BITS-1:0] MID_CODE = {1'b1, {(ADC_BITS-1){1'b0}}};
  localparam logic [PTR_W:0]      FULL_LVL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]      LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

`ifdef TI_ADC_OFFSET_CAL_EN
  // Clamp an extended signed difference into the unsigned code range.
  function automatic logic [ADC_BITS-1:0] clamp_code(input logic signed [EW-1:0] v);
    if (v[EW-1])
      clamp_code = '0;
    else if (v[ADC_BITS])
      clamp_code = '1;
    else
      clamp_code = v[ADC_BITS-1:0];
  endfunction

  function automatic logic [ADC_BITS-1:0] correct_way(input logic [ADC_BITS-1:0] code,
                                                      input logic signed [CAL_BITS-1:0] off);
    logic signed [EW-1:0] c_ext;
    logic signed [EW-1:0] o_ext;
    c_ext = signed'({2'b00, code});
    o_ext = EW'(off);
    correct_way = clamp_code(c_ext - o_ext);
  endfunction
`else
  logic unused_cal;
  assign unused_cal = ^cal_offset;
`endif

  logic [DW-1:0]         corr_d;

  logic                  s1_vld_q, s1_vld_d;
  logic [DW-1:0]         s1_data_q;
  logic [CNT_BITS-1:0]   s1_stamp_q;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]         mem_data [FIFO_DEPTH];
  logic [CNT_BITS-1:0]   mem_frame[FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        level_q, level_d;
  logic                  ovf_q, ovf_d;

  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;

  // Correction and masking, ahead of the stage-1 register.
  always_comb begin
    corr_d = '0;
    for (int i = 0; i < ADC_WAYS; i++) begin
      if (!way_mask[i])
        corr_d[i*ADC_BITS +: ADC_BITS] = MID_CODE;
      else
`ifdef TI_ADC_OFFSET_CAL_EN
        corr_d[i*ADC_BITS +: ADC_BITS] = correct_way(in_data[i*ADC_BITS +: ADC_BITS],
                                                     cal_offset[i*CAL_BITS +: CAL_BITS]);
`else
        corr_d[i*ADC_BITS +: ADC_BITS] = in_data[i*ADC_BITS +: ADC_BITS];
`endif
    end
  end

  // FIFO control: a full FIFO still takes a push if the head leaves this cycle.
  always_comb begin
    pop      = out_valid && out_ready;
    full     = (level_q == FULL_LVL);
    push_ok  = s1_vld_q && (!full || pop);
    drop     = s1_vld_q && full && !pop;

    s1_vld_d = in_valid;
    cnt_d    = in_valid ? (cnt_q + CNT_ONE) : cnt_q;
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // Setting wins over clearing.
    if (drop)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
    else
      ovf_d = ovf_q;
  end

  // Stage 1: control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Stage 1: corrected frame and its stamp (stamp = count before increment)
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_data_q  <= corr_d;
      s1_stamp_q <= cnt_q;
    end
  end

  // Stage 2: frame buffer write
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr_q]  <= s1_data_q;
      mem_frame[wr_ptr_q] <= s1_stamp_q;
    end
  end

  // Head outputs are gated by level so they read zero whenever empty or in reset.
  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_data[rd_ptr_q]  : '0;
  assign out_frame  = out_valid ? mem_frame[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ti_adc_frame_align.sv
module tb_ti_adc_frame_align;

  localparam int W = 8;
  localparam int B = 9;
  localparam int C = 6;
  localparam int D = 4;
  localparam int N = 16;

`ifdef TI_ADC_OFFSET_CAL_EN
  localparam int EXP_100_5   = 95;
  localparam int EXP_3_10    = 0;
  localparam int EXP_508_M20 = 511;
  localparam int EXP_200_M7  = 207;
`else
  localparam int EXP_100_5   = 100;
  localparam int EXP_3_10    = 3;
  localparam int EXP_508_M20 = 508;
  localparam int EXP_200_M7  = 200;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid;
  logic [W*B-1:0] in_data;
  logic [W*C-1:0] cal_offset;
  logic [W-1:0]   way_mask;
  logic           clr_ovf;
  logic           out_ready;
  logic           out_valid;
  logic [W*B-1:0] out_data;
  logic [N-1:0]   out_frame;
  logic [2:0]     fifo_level;
  logic           overflow;

  typedef struct {
    logic [W*B-1:0] data;
    logic [N-1:0]   frame;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   tb_cnt = 0;

  ti_adc_frame_align #(
    .ADC_WAYS(W), .ADC_BITS(B), .CAL_BITS(C), .FIFO_DEPTH(D), .CNT_BITS(N)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .cal_offset(cal_offset), .way_mask(way_mask), .clr_ovf(clr_ovf),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_frame(out_frame), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference per-way result.
  function automatic logic [B-1:0] mdl(input int code, input int off, input bit en);
    int v;
    if (!en) return 9'd256;
`ifdef TI_ADC_OFFSET_CAL_EN
    v = code - off;
    if (v < 0)   v = 0;
    if (v > 511) v = 511;
`else
    v = code;
`endif
    return v[B-1:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Way 0/1 are directed; ways 2..7 carry a fixed background pattern.
  task automatic issue(input int c0, input int o0, input int c1, input int o1,
                       input logic [W-1:0] mask, input bit accept);
    exp_t e;
    int code, off;
    logic [31:0] cv, ov, sv;
    for (int i = 0; i < W; i++) begin
      code = (i == 0) ? c0 : (i == 1) ? c1 : 40 * i;
      off  = (i == 0) ? o0 : (i == 1) ? o1 : i - 4;
      cv = code;
      ov = off;
      in_data[i*B +: B]    = cv[B-1:0];
      cal_offset[i*C +: C] = ov[C-1:0];
      e.data[i*B +: B]     = mdl(code, off, mask[i]);
    end
    sv       = tb_cnt;
    e.frame  = sv[N-1:0];
    tb_cnt++;
    way_mask = mask;
    in_valid = 1'b1;
    if (accept) sbq.push_back(e);
  endtask

  task automatic send(input int c0, input int o0, input int c1, input int o1,
                      input logic [W-1:0] mask, input bit accept);
    issue(c0, o0, c1, o1, mask, accept);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int maxc);
    int n = 0;
    while (fifo_level != 0 && n < maxc) begin
      tick;
      n++;
    end
    chk("drain_done", {125'd0, fifo_level}, 128'd0);
  endtask

  // Monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got frame %0h expected none", out_frame);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_frame", {112'd0, out_frame}, {112'd0, e.frame});
        chk("sb_data", {56'd0, out_data}, {56'd0, e.data});
      end
    end
  end

  initial begin
    logic [W*B-1:0] hold_d;
    logic [N-1:0]   hold_f;
    in_valid = 0; in_data = '0; cal_offset = '0; way_mask = '1;
    clr_ovf = 0; out_ready = 0;
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_level", {125'd0, fifo_level}, 128'd0);
    chk("rst_ovf", {127'd0, overflow}, 128'd0);
    chk("rst_frame", {112'd0, out_frame}, 128'd0);
    chk("rst_data", {56'd0, out_data}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First frame latency and offset correction.
    out_ready = 1'b1;
    send(100, 5, 50, 0, 8'hFF, 1'b1);
    chk("lat_early", {127'd0, out_valid}, 128'd0);
    tick;
    chk("lat_valid", {127'd0, out_valid}, 128'd1);
    chk("lat_frame", {112'd0, out_frame}, 128'd0);
    chk("lat_way0", {119'd0, out_data[8:0]}, 128'(EXP_100_5));

    // Clamp at both ends.
    send(3, 10, 508, -20, 8'hFF, 1'b1);
    tick;
    chk("clamp_lo", {119'd0, out_data[8:0]}, 128'(EXP_3_10));
    chk("clamp_hi", {119'd0, out_data[17:9]}, 128'(EXP_508_M20));

    // Masking of way 0; way 1 offset.
    send(77, 3, 200, -7, 8'hFE, 1'b1);
    tick;
    chk("mask_way0", {119'd0, out_data[8:0]}, 128'd256);
    chk("way1_off", {119'd0, out_data[17:9]}, 128'(EXP_200_M7));
    wait_empty(10);

    // Overflow: restart counting from reset, stall, push five.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tb_cnt = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(10 + k, 0, 300, 1, 8'hFF, k < 4);
    tick; tick;
    chk("ovf_level", {125'd0, fifo_level}, 128'd4);
    chk("ovf_flag", {127'd0, overflow}, 128'd1);
    chk("ovf_head", {112'd0, out_frame}, 128'd0);
    hold_d = out_data;
    hold_f = out_frame;
    tick;
    chk("stall_data", {56'd0, out_data}, {56'd0, hold_d});
    chk("stall_frame", {112'd0, out_frame}, {112'd0, hold_f});
    out_ready = 1'b1;
    wait_empty(10);
    send(400, 0, 1, 0, 8'hFF, 1'b1);
    tick;
    chk("after_drop_stamp", {112'd0, out_frame}, 128'd5);
    chk("ovf_sticky", {127'd0, overflow}, 128'd1);
    clr_ovf = 1'b1;
    tick;
    clr_ovf = 1'b0;
    chk("ovf_cleared", {127'd0, overflow}, 128'd0);
    wait_empty(10);

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(20 * k, 1, 60, -1, 8'hFF, 1'b1);
    tick;
    chk("full_level", {125'd0, fifo_level}, 128'd4);
    issue(123, 2, 321, -3, 8'hFF, 1'b1);
    tick;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("pp_level", {125'd0, fifo_level}, 128'd4);
    chk("pp_no_ovf", {127'd0, overflow}, 128'd0);

    // Drop coinciding with clr_ovf: set wins.
    issue(5, 0, 6, 0, 8'hFF, 1'b0);
    tick;
    in_valid = 1'b0;
    clr_ovf  = 1'b1;
    tick;
    clr_ovf  = 1'b0;
    chk("set_prio", {127'd0, overflow}, 128'd1);
    out_ready = 1'b1;
    wait_empty(10);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(30 + k, 0, 90, 0, 8'hFF, 1'b1);
    tick;
    chk("pre_rst_level", {125'd0, fifo_level}, 128'd3);
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("arst_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_level", {125'd0, fifo_level}, 128'd0);
    chk("arst_ovf", {127'd0, overflow}, 128'd0);
    tick;
    rst = 1'b0;
    tb_cnt = 0;
    out_ready = 1'b1;
    send(250, -4, 260, 4, 8'hFF, 1'b1);
    tick;
    chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
    chk("post_rst_frame", {112'd0, out_frame}, 128'd0);
    wait_empty(10);
    tick;
    chk("sb_empty", 128'(sbq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
